// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-organised on-chip memory.
// Supports byte, halfword and word transfers with little-endian lanes, a
// configurable number of data-phase wait states, a two-cycle ERROR response
// for out-of-range, oversized or misaligned transfers, and a read-after-write
// bypass so that back-to-back write/read to the same word returns fresh data.
module ahb_slave_mem #(
   parameter int AHB_DW      = 32,
   parameter int AHB_AW      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsel,
   input  logic [AHB_AW-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [AHB_DW-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic [AHB_DW-1:0] hrdata,
   output logic              hresp
);

   localparam int NB        = AHB_DW / 8;
   localparam int LANE_W    = $clog2(NB);
   localparam int IDX_W     = $clog2(MEM_DEPTH);
   localparam int MEM_BYTES = MEM_DEPTH * NB;
   localparam logic [LANE_W-1:0] LANE_ONES = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [AHB_AW-1:0]     r_haddr;
   logic                  r_hwrite;
   logic [2:0]            r_hsize;
   logic                  r_dp_active;
   logic [AHB_DW-1:0]     r_hrdata;
   logic [AHB_DW-1:0]     r_mem [MEM_DEPTH];

   logic                  w_hreadyout;
   logic                  w_hresp;
   logic                  w_err;
   logic                  w_accept;
   logic                  w_accept_ok;
   logic                  w_wr_en;
   logic [LANE_W-1:0]     w_size_lsb;
   logic [IDX_W-1:0]      w_idx;
   logic [IDX_W-1:0]      w_dp_idx;
   logic [NB-1:0]         w_dp_mask;
   logic [AHB_DW-1:0]     w_rd_word;
   logic                  w_unused_ok;

   // Enabled byte lanes: 2^size bytes starting at the in-word byte offset.
   function automatic logic [NB-1:0] lane_mask(input logic [LANE_W-1:0] off,
                                               input logic [2:0] size);
      lane_mask = '0;
      for (int b = 0; b < NB; b++)
         lane_mask[b] = (b >= int'(off)) && (b < int'(off) + (1 << size));
   endfunction

   // Address-phase error decode: out of range, too wide, or misaligned.
   assign w_size_lsb = ~(LANE_ONES << hsize);
   assign w_err      = (64'(haddr) >= 64'(MEM_BYTES))
                     || (hsize > 3'(LANE_W))
                     || (|(haddr[LANE_W-1:0] & w_size_lsb));

   // A new address phase is only taken while this slave is itself ready.
   assign w_accept    = hsel & hready & htrans[1] & w_hreadyout;
   assign w_accept_ok = w_accept & ~w_err;

   assign w_idx     = haddr[IDX_W+LANE_W-1:LANE_W];
   assign w_dp_idx  = r_haddr[IDX_W+LANE_W-1:LANE_W];
   assign w_dp_mask = lane_mask(r_haddr[LANE_W-1:0], r_hsize);
   assign w_wr_en   = r_dp_active & r_hwrite & w_hreadyout;

   assign hreadyout   = w_hreadyout;
   assign hresp       = w_hresp;
   assign hrdata      = r_hrdata;
   assign w_unused_ok = &{1'b0, hburst, htrans[0]};

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Response decode and next-state logic.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      w_state_nxt = r_state;
      w_hreadyout = 1'b1;
      w_hresp     = 1'b0;
      case (r_state)
         ST_WAIT: w_hreadyout = (r_cnt == 4'(WAIT_STATES));
         ST_ERR1: begin
            w_hreadyout = 1'b0;
            w_hresp     = 1'b1;
         end
         ST_ERR2: w_hresp = 1'b1;
         default: ;
      endcase
      if (w_hreadyout) begin
         if (hsel && hready && htrans[1])
            w_state_nxt = w_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_IDLE);
         else
            w_state_nxt = ST_IDLE;
      end else if (r_state == ST_ERR1) begin
         w_state_nxt = ST_ERR2;
      end
   end

   // Wait counter: counts the low-hreadyout cycles of the WAIT state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  r_cnt <= '0;
      else if (r_state == ST_WAIT && !w_hreadyout) r_cnt <= r_cnt + 4'd1;
      else                                        r_cnt <= '0;
   end

   // Address-phase capture; a data phase is armed only for valid transfers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_haddr     <= '0;
         r_hwrite    <= 1'b0;
         r_hsize     <= '0;
         r_dp_active <= 1'b0;
      end else if (w_hreadyout) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_dp_active <= w_accept_ok;
         if (w_accept) begin
            r_haddr  <= haddr;
            r_hwrite <= hwrite;
            r_hsize  <= hsize;
         end
      end
   end

   // Read word, merged with a write completing at the same edge to that word.
   always_comb begin
      w_rd_word = r_mem[w_idx];
      if (w_wr_en && (w_dp_idx == w_idx)) begin
         for (int b = 0; b < NB; b++)
            if (w_dp_mask[b]) w_rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
   end

   // Read data register: loaded on a read acceptance, zero otherwise, held in wait states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            r_hrdata <= '0;
      else if (w_hreadyout) r_hrdata <= (w_accept_ok && !hwrite) ? w_rd_word : '0;
   end

   // Memory write of the enabled byte lanes at the completing data-phase edge.
   // NOTE: the memory array has no reset; contents survive reset and only the control path is cleared.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < NB; b++)
            if (w_dp_mask[b]) r_mem[w_dp_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: a zero-wait instance driven from a
// per-cycle vector table, and a two-wait-state instance driven by hand-written
// sequences for wait timing, error timing and reset during a transfer.
module tb_ahb_slave_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        hsel0, hsel2;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic        hreadyout0, hresp0, hreadyout2, hresp2;
   logic [31:0] hrdata0, hrdata2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb_slave_mem #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(hreadyout0), .hreadyout(hreadyout0), .hrdata(hrdata0), .hresp(hresp0));

   ahb_slave_mem #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
      .clk(clk), .reset(reset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(hreadyout2), .hreadyout(hreadyout2), .hrdata(hrdata2), .hresp(hresp2));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One row per clock: address phase of this row's transfer, hwdata for the
   // previous row's write, and the data-phase response expected after the edge.
   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_rdy;
      logic        exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2;

   function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rdy, input logic resp,
                               input logic [31:0] rdata);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
      v.wdata = wdata; v.exp_rdy = rdy; v.exp_resp = resp; v.exp_rdata = rdata;
      return v;
   endfunction

   task automatic drive(input logic wr, input logic [1:0] trans, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = wdata;
   endtask

   // Full transfer on the wait-state instance; hwdata follows into the data phase.
   task automatic xfer2(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic resp, output int waits);
      hsel2 = 1'b1;
      drive(wr, T_NSEQ, size, addr, 32'h0);
      @(posedge clk); #1;
      hsel2 = 1'b0;
      drive(1'b0, T_IDLE, 3'd2, 32'h0, wdata);
      waits = 0;
      while (!hreadyout2 && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      rdata = hrdata2;
      resp  = hresp2;
      @(posedge clk); #1;
   endtask

   vec_t        vecs[$];
   logic [31:0] rd;
   logic        rs;
   int          wt;

   initial begin
      reset = 1'b1; hsel0 = 1'b0; hsel2 = 1'b0; hburst = 3'd0;
      drive(1'b0, T_IDLE, 3'd2, 32'h0, 32'h0);
      #1;
      check("reset_rdy0",  {63'd0, hreadyout0}, 64'd1);
      check("reset_resp0", {63'd0, hresp0}, 64'd0);
      check("reset_rdata0", {32'd0, hrdata0}, 64'd0);
      check("reset_rdy2",  {63'd0, hreadyout2}, 64'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // sel trans  wr size addr          wdata          rdy resp rdata
      vecs.push_back(mk(1, T_NSEQ, 1, 3'd2, 32'h10,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'hDEADBEEF, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, T_NSEQ, 1, 3'd2, 32'h20,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 1, 3'd0, 32'h22,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h20,  32'hABABABAB, 1, 0, 32'h00AB0000));
      vecs.push_back(mk(1, T_IDLE, 1, 3'd2, 32'h20,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h20,  32'h0,        1, 0, 32'h00AB0000));
      vecs.push_back(mk(1, T_BUSY, 1, 3'd2, 32'h10,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h11111111, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h400, 32'h0,        0, 1, 32'h0));
      vecs.push_back(mk(1, T_IDLE, 0, 3'd2, 32'h0,   32'h0,        1, 1, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 1, 3'd1, 32'h11,  32'h0,        0, 1, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 1, 3'd2, 32'h10,  32'hFFFFFFFF, 1, 1, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h12345678, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd3, 32'h0,   32'h0,        0, 1, 32'h0));
      vecs.push_back(mk(1, T_IDLE, 0, 3'd2, 32'h0,   32'h0,        1, 1, 32'h0));
      vecs.push_back(mk(1, T_IDLE, 0, 3'd2, 32'h0,   32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(0, T_NSEQ, 1, 3'd2, 32'h10,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, T_NSEQ, 1, 3'd1, 32'h12,  32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'hCAFE1234, 1, 0, 32'hCAFEBEEF));
      vecs.push_back(mk(1, T_IDLE, 0, 3'd2, 32'h0,   32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'hCAFEBEEF));

      foreach (vecs[i]) begin
         hsel0 = vecs[i].sel;
         drive(vecs[i].wr, vecs[i].trans, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         @(posedge clk); #1;
         check($sformatf("v%0d_rdy", i),   {63'd0, hreadyout0}, {63'd0, vecs[i].exp_rdy});
         check($sformatf("v%0d_resp", i),  {63'd0, hresp0},     {63'd0, vecs[i].exp_resp});
         check($sformatf("v%0d_rdata", i), {32'd0, hrdata0},    {32'd0, vecs[i].exp_rdata});
      end
      hsel0 = 1'b0;
      drive(1'b0, T_IDLE, 3'd2, 32'h0, 32'h0);
      @(posedge clk); #1;

      // Two wait states: write then read back.
      xfer2(1'b1, 3'd2, 32'h10, 32'h11223344, rd, rs, wt);
      check("ws2_wr_waits", 64'(wt), 64'd2);
      check("ws2_wr_resp", {63'd0, rs}, 64'd0);
      xfer2(1'b0, 3'd2, 32'h10, 32'h0, rd, rs, wt);
      check("ws2_rd_waits", 64'(wt), 64'd2);
      check("ws2_rd_resp", {63'd0, rs}, 64'd0);
      check("ws2_rd_data", {32'd0, rd}, 64'h11223344);

      // Error on the wait-state instance: one low cycle, then ERROR completion.
      xfer2(1'b0, 3'd2, 32'h400, 32'h0, rd, rs, wt);
      check("ws2_err_waits", 64'(wt), 64'd1);
      check("ws2_err_resp", {63'd0, rs}, 64'd1);
      check("ws2_err_data", {32'd0, rd}, 64'd0);

      // Reset during the second wait cycle of a write aborts it.
      xfer2(1'b1, 3'd2, 32'h30, 32'h55AA55AA, rd, rs, wt);
      hsel2 = 1'b1;
      drive(1'b1, T_NSEQ, 3'd2, 32'h30, 32'h0);
      @(posedge clk); #1;
      hsel2 = 1'b0;
      drive(1'b0, T_IDLE, 3'd2, 32'h0, 32'hFFFFFFFF);
      check("rst_w1_rdy", {63'd0, hreadyout2}, 64'd0);
      @(posedge clk); #1;
      check("rst_w2_rdy", {63'd0, hreadyout2}, 64'd0);
      #1 reset = 1'b1;
      #1;
      check("rst_async_rdy", {63'd0, hreadyout2}, 64'd1);
      check("rst_async_resp", {63'd0, hresp2}, 64'd0);
      check("rst_async_rdata", {32'd0, hrdata2}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      hwdata = 32'h0;
      xfer2(1'b0, 3'd2, 32'h30, 32'h0, rd, rs, wt);
      check("post_rst_waits", 64'(wt), 64'd2);
      check("post_rst_resp", {63'd0, rs}, 64'd0);
      check("post_rst_data", {32'd0, rd}, 64'h55AA55AA);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
